pipe_adder: RTL and testbench
=============================

Name: pipe_adder

Overview:
- Parametrised, pipelined successor to the team's 2-bit combinational carry adder.
- Adds or subtracts two WIDTH-bit operands with carry-in.
- Splits the carry chain into STAGES equal slices, one slice per clock, so wide adders close timing.
- Valid/ready handshakes with backpressure on both sides; sits between datapath producers and consumers in Cash-generated designs.

Parameters:
- WIDTH, 32, operand/result width in bits.
- STAGES, 4, pipeline depth and number of carry slices. WIDTH % STAGES must be 0; otherwise elaboration error.
- CHUNK, WIDTH/STAGES, derived slice width; not user-overridable.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- io_in_valid  input  1  operand beat valid.
- io_in_ready  output  1  block accepts beat this cycle.
- io_sub  input  1  1 = subtract (lhs - rhs), 0 = add.
- io_cin  input  1  carry-in, add mode only.
- io_lhs  input  WIDTH  left operand.
- io_rhs  input  WIDTH  right operand.
- io_out_valid  output  1  result valid.
- io_out_ready  input  1  consumer accepts result.
- io_out  output  WIDTH  sum/difference, modulo 2^WIDTH.
- io_cout  output  1  carry out of MSB (sub: 1 = no borrow).
- io_ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (reset=0, async): all stage valid bits clear. Data/carry registers are don't-care.
  - io_out_valid=0; io_out, io_cout, io_ovf = 0 (held via output gating while invalid).
  - io_in_ready=1 as soon as reset deasserts.
- Effective operands:
  - rhs_e = io_sub ? ~io_rhs : io_rhs.
  - c0 = io_sub ? 1 : io_cin; in sub mode io_cin is ignored.
- Stage k (0..STAGES-1):
  - Adds slice k of lhs and rhs_e plus the carry registered by stage k-1 (c0 for stage 0).
  - Registers the CHUNK-bit result slice and the slice carry.
  - Higher slices are carried forward unmodified (skew registers); lower result slices are carried forward already computed.
- Final stage:
  - io_out = concatenated result slices.
  - io_cout = final slice carry.
  - io_ovf = (lhs[W-1] == rhs_e[W-1]) && (out[W-1] != lhs[W-1]), using the registered MSBs of lhs and rhs_e.
- Latency: exactly STAGES cycles from accepted input beat (io_in_valid & io_in_ready at edge) to io_out_valid, when io_out_ready=1.
- Throughput: 1 beat/cycle with io_out_ready held high.
- Handshake, per-stage flow control:
  - Stage k advances when its successor is empty or advancing. The output stage advances when io_out_ready=1 or io_out_valid=0.
  - io_in_ready = !valid[0] | advance[0]. This is a combinational path from io_out_ready; accepted.
  - Bubbles collapse: an empty stage accepts while downstream is stalled.
  - Results stay stable while io_out_valid=1 and io_out_ready=0.
- Ordering: strictly FIFO, no drops, no duplicates.
- Simultaneous accept at input and drain at output in the same cycle is legal and is the steady state.
- io_in_valid=1 with io_in_ready=0: beat not taken; producer holds it.
- Reset mid-operation: all in-flight beats discarded; no partial result is ever presented.
- STAGES=1: single register stage, latency 1, same handshake.

Decomposition:
- Package pipe_adder_pkg: CHUNK derivation function, WIDTH%STAGES check, stage-index constants.
- One sub-module, adder_stage:
  - CHUNK-bit slice adder with carry register, valid bit and pass-through skew registers.
  - pipe_adder instantiates STAGES of them and wires carry, valid and advance chains.

Test Plan:
- Carry propagation (defaults): lhs=0xFFFFFFFF, rhs=0, cin=1, sub=0 → after 4 cycles out=0x00000000, cout=1, ovf=0.
- Subtract with borrow: lhs=5, rhs=7, sub=1, cin=1 (ignored) → out=0xFFFFFFFE, cout=0, ovf=0.
- Signed overflow:
  - 0x7FFFFFFF+1 → out=0x80000000, ovf=1, cout=0.
  - 0x80000000-1 (sub) → out=0x7FFFFFFF, ovf=1, cout=1.
- Backpressure: stream 6 beats (lhs=i, rhs=i, i=1..6), hold io_out_ready=0 for cycles 5-8.
  - io_in_ready drops once all 4 stages are full.
  - Outputs 2,4,6,8,10,12 arrive in order, no loss; io_out stable while stalled.
- Reset mid-flight: assert reset with 3 beats in flight → io_out_valid=0 immediately (async), io_in_ready=1 after release, no stale result appears later.
- Reconfigured WIDTH=8, STAGES=1: 0xFF+0x01, cin=0 → out=0x00, cout=1, latency 1; back-to-back beats at full rate.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// Shared constants and helpers for the pipelined adder: slice-width derivation and
// width/stage compatibility check.
package pipe_adder_pkg;

  localparam int unsigned StageFirst = 0;

  function automatic int unsigned chunk_of(int unsigned width, int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  function automatic bit split_ok(int unsigned width, int unsigned stages);
    return (stages != 0) && (width != 0) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One carry slice of the pipelined adder: adds slice K of the operands with the incoming
// carry and carries the full operand/result words forward with a valid bit.
module adder_stage
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4,
  parameter int unsigned K      = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] lhs_i,
  input  logic [WIDTH-1:0] rhs_i,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             carry_i,
  input  logic             succ_ready_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] lhs_o,
  output logic [WIDTH-1:0] rhs_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  localparam int unsigned Chunk = chunk_of(WIDTH, STAGES);
  localparam int unsigned Lo    = K * Chunk;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] lhs_q, rhs_q, sum_q, sum_d;
  logic             carry_q;
  logic [Chunk:0]   slice_sum;
  logic             load;

  // An empty stage always loads, so bubbles collapse under downstream stall.
  assign load    = !valid_q || succ_ready_i;
  assign ready_o = load;

  assign slice_sum = {1'b0, lhs_i[Lo +: Chunk]} + {1'b0, rhs_i[Lo +: Chunk]}
                   + {{Chunk{1'b0}}, carry_i};

  always_comb begin
    sum_d = sum_i;
    sum_d[Lo +: Chunk] = slice_sum[Chunk-1:0];
  end

  always_comb begin
    valid_d = valid_q;
    if (load) valid_d = valid_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load && valid_i) begin
      lhs_q   <= lhs_i;
      rhs_q   <= rhs_i;
      sum_q   <= sum_d;
      carry_q <= slice_sum[Chunk];
    end
  end

  assign valid_o = valid_q;
  assign lhs_o   = lhs_q;
  assign rhs_o   = rhs_q;
  assign sum_o   = sum_q;
  assign carry_o = carry_q;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract with carry-in, one carry slice per stage, valid/ready on both sides.
// Outputs are forced to zero whenever no result is valid.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic             io_sub,
  input  logic             io_cin,
  input  logic [WIDTH-1:0] io_lhs,
  input  logic [WIDTH-1:0] io_rhs,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out,
  output logic             io_cout,
  output logic             io_ovf
);

  if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
    $error("pipe_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  // Index k is the input of stage k; index STAGES is the output of the last stage.
  logic [WIDTH-1:0] lhs_c [STAGES+1];
  logic [WIDTH-1:0] rhs_c [STAGES+1];
  logic [WIDTH-1:0] sum_c [STAGES+1];
  logic [STAGES:0]  valid_c;
  logic [STAGES:0]  carry_c;
  logic [STAGES:0]  ready_c;

  assign lhs_c[StageFirst]   = io_lhs;
  assign rhs_c[StageFirst]   = io_sub ? ~io_rhs : io_rhs;
  assign sum_c[StageFirst]   = '0;
  assign valid_c[StageFirst] = io_in_valid;
  assign carry_c[StageFirst] = io_sub ? 1'b1 : io_cin;
  assign ready_c[STAGES]     = io_out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_stage #(
      .WIDTH (WIDTH),
      .STAGES(STAGES),
      .K     (k)
    ) u_stage (
      .clk_i       (clk),
      .rst_ni      (reset),
      .valid_i     (valid_c[k]),
      .lhs_i       (lhs_c[k]),
      .rhs_i       (rhs_c[k]),
      .sum_i       (sum_c[k]),
      .carry_i     (carry_c[k]),
      .succ_ready_i(ready_c[k+1]),
      .ready_o     (ready_c[k]),
      .valid_o     (valid_c[k+1]),
      .lhs_o       (lhs_c[k+1]),
      .rhs_o       (rhs_c[k+1]),
      .sum_o       (sum_c[k+1]),
      .carry_o     (carry_c[k+1])
    );
  end

  logic lhs_msb, rhs_msb, sum_msb;
  logic unused_lo;

  assign lhs_msb   = lhs_c[STAGES][WIDTH-1];
  assign rhs_msb   = rhs_c[STAGES][WIDTH-1];
  assign sum_msb   = sum_c[STAGES][WIDTH-1];
  assign unused_lo = ^{lhs_c[STAGES][WIDTH-2:0], rhs_c[STAGES][WIDTH-2:0]};

  assign io_in_ready  = ready_c[StageFirst];
  assign io_out_valid = valid_c[STAGES];
  assign io_out       = io_out_valid ? sum_c[STAGES] : '0;
  assign io_cout      = io_out_valid & carry_c[STAGES];
  assign io_ovf       = io_out_valid & (lhs_msb == rhs_msb) & (sum_msb != lhs_msb);

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench: a 32-bit/4-stage adder driven through a scoreboard, plus an
// 8-bit/1-stage instance checked by hand.
module tb_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_in_valid, a_in_ready, a_sub, a_cin, a_out_valid, a_out_ready, a_cout, a_ovf;
  logic [31:0] a_lhs, a_rhs, a_out;
  logic        b_in_valid, b_in_ready, b_sub, b_cin, b_out_valid, b_out_ready, b_cout, b_ovf;
  logic [7:0]  b_lhs, b_rhs, b_out;

  pipe_adder u_dut_a (
    .clk         (clk),
    .reset       (rst_n),
    .io_in_valid (a_in_valid),
    .io_in_ready (a_in_ready),
    .io_sub      (a_sub),
    .io_cin      (a_cin),
    .io_lhs      (a_lhs),
    .io_rhs      (a_rhs),
    .io_out_valid(a_out_valid),
    .io_out_ready(a_out_ready),
    .io_out      (a_out),
    .io_cout     (a_cout),
    .io_ovf      (a_ovf)
  );

  pipe_adder #(
    .WIDTH (8),
    .STAGES(1)
  ) u_dut_b (
    .clk         (clk),
    .reset       (rst_n),
    .io_in_valid (b_in_valid),
    .io_in_ready (b_in_ready),
    .io_sub      (b_sub),
    .io_cin      (b_cin),
    .io_lhs      (b_lhs),
    .io_rhs      (b_rhs),
    .io_out_valid(b_out_valid),
    .io_out_ready(b_out_ready),
    .io_out      (b_out),
    .io_cout     (b_cout),
    .io_ovf      (b_ovf)
  );

  typedef struct packed {
    logic [31:0] out;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    string       name;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic        sub;
    logic        cin;
    res_t        exp;
  } vec_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   out_seen = 0;
  res_t scb[$];
  bit   saw_in_low = 0;
  bit   stall_prev = 0;
  res_t stall_val;
  bit   rand_bp = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
  endtask

  // Reference: wide integer arithmetic; overflow when the signed result does not fit.
  function automatic res_t model(logic [31:0] lhs, logic [31:0] rhs, logic sub, logic cin);
    res_t        r;
    logic [32:0] ur;
    longint      sa, sr;
    sa = longint'($signed(lhs));
    if (sub) begin
      ur     = {1'b0, lhs} - {1'b0, rhs};
      r.cout = (lhs >= rhs);
      sr     = sa - longint'($signed(rhs));
    end else begin
      ur     = {1'b0, lhs} + {1'b0, rhs} + {32'd0, cin};
      r.cout = ur[32];
      sr     = sa + longint'($signed(rhs)) + longint'(cin);
    end
    r.out = ur[31:0];
    r.ovf = (sr != longint'($signed(r.out)));
    return r;
  endfunction

  // Monitor for the 32-bit instance; samples mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 0;
      end else begin
        if (!a_in_ready) saw_in_low = 1;
        if (a_out_valid && !a_out_ready) begin
          if (stall_prev) check("stall_stable", {30'd0, a_out, a_cout, a_ovf}, {30'd0, stall_val});
          stall_prev = 1;
          stall_val  = '{a_out, a_cout, a_ovf};
        end else begin
          stall_prev = 0;
        end
        if (a_out_valid && a_out_ready) begin
          out_seen++;
          if (scb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_output: got 0x%08h required no result", a_out);
          end else begin
            res_t e;
            e = scb.pop_front();
            check("out", {32'd0, a_out}, {32'd0, e.out});
            check("cout", {63'd0, a_cout}, {63'd0, e.cout});
            check("ovf", {63'd0, a_ovf}, {63'd0, e.ovf});
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_bp) a_out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat was taken.
  task automatic send_a(logic [31:0] lhs, logic [31:0] rhs, logic sub, logic cin, res_t e);
    int t = 0;
    a_lhs = lhs; a_rhs = rhs; a_sub = sub; a_cin = cin; a_in_valid = 1'b1;
    @(negedge clk);
    while (!a_in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!a_in_ready) begin
      n_checks++;
      $display("FAIL send_timeout: got in_ready=0 required 1 within 50 cycles");
    end else begin
      scb.push_back(e);
    end
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
  endtask

  task automatic drain_a();
    int t = 0;
    while (scb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (scb.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d pending required 0", scb.size());
      scb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    int          lat, seen0;
    logic [8:0]  bexp [5];
    logic [31:0] l, r;
    logic        s, c;

    vecs.push_back('{"carry_prop", 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, '{32'h0000_0000, 1'b1, 1'b0}});
    vecs.push_back('{"sub_borrow", 32'd5, 32'd7, 1'b1, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0}});
    vecs.push_back('{"ovf_add", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1}});
    vecs.push_back('{"ovf_sub", 32'h8000_0000, 32'd1, 1'b1, 1'b0, '{32'h7FFF_FFFF, 1'b1, 1'b1}});
    vecs.push_back('{"mixed", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, '{32'hACF1_3568, 1'b0, 1'b0}});
    vecs.push_back('{"slice_ripple", 32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1'b1, '{32'h0, 1'b1, 1'b0}});
    vecs.push_back('{"sub_equal", 32'd3, 32'd3, 1'b1, 1'b0, '{32'h0, 1'b1, 1'b0}});

    rst_n = 1'b0;
    a_in_valid = 0; a_sub = 0; a_cin = 0; a_lhs = 0; a_rhs = 0; a_out_ready = 1;
    b_in_valid = 0; b_sub = 0; b_cin = 0; b_lhs = 0; b_rhs = 0; b_out_ready = 1;
    #1;
    check("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
    check("rst_out", {32'd0, a_out}, 64'd0);
    check("rst_cout_ovf", {62'd0, a_cout, a_ovf}, 64'd0);
    check("rst_b_out_valid", {63'd0, b_out_valid}, 64'd0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("in_ready_after_rst", {62'd0, a_in_ready, b_in_ready}, 64'd3);
    @(posedge clk);
    #1;

    // Single beat into an empty pipe: latency in edges from accept to out_valid.
    send_a(vecs[0].lhs, vecs[0].rhs, vecs[0].sub, vecs[0].cin, vecs[0].exp);
    lat = 1;
    while (!a_out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'd4);
    drain_a();

    foreach (vecs[i]) send_a(vecs[i].lhs, vecs[i].rhs, vecs[i].sub, vecs[i].cin, vecs[i].exp);
    drain_a();

    // Random operands under random backpressure.
    rand_bp = 1;
    for (int i = 0; i < 24; i++) begin
      l = $urandom; r = $urandom; s = 1'($urandom_range(0, 1)); c = 1'($urandom_range(0, 1));
      send_a(l, r, s, c, model(l, r, s, c));
    end
    rand_bp = 0;
    a_out_ready = 1;
    drain_a();

    // Stalled stream: pipe must fill, hold, then release in order.
    saw_in_low = 0;
    seen0 = out_seen;
    a_out_ready = 0;
    fork
      for (int i = 1; i <= 6; i++) send_a(32'(i), 32'(i), 1'b0, 1'b0, model(32'(i), 32'(i), 0, 0));
      begin
        repeat (8) @(posedge clk);
        #1;
        a_out_ready = 1;
      end
    join
    drain_a();
    check("in_ready_dropped", {63'd0, saw_in_low}, 64'd1);
    check("stream_count", 64'(out_seen - seen0), 64'd6);

    // Reset with beats in flight: nothing may emerge afterwards.
    a_out_ready = 0;
    for (int i = 0; i < 3; i++) send_a(32'(100 + i), 32'd1, 1'b0, 1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {63'd0, a_out_valid}, 64'd0);
    scb.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("in_ready_post_rst", {63'd0, a_in_ready}, 64'd1);
    a_out_ready = 1;
    seen0 = out_seen;
    repeat (10) @(posedge clk);
    #1;
    check("no_stale_result", 64'(out_seen - seen0), 64'd0);
    check("idle_out_zero", {31'd0, a_out_valid, a_out}, 64'd0);

    // 8-bit single-stage instance.
    b_lhs = 8'hFF; b_rhs = 8'h01; b_cin = 0; b_sub = 0; b_in_valid = 1;
    @(negedge clk);
    check("b_in_ready", {63'd0, b_in_ready}, 64'd1);
    @(posedge clk);
    #1;
    check("b_latency1_valid", {63'd0, b_out_valid}, 64'd1);
    check("b_wrap", {54'd0, b_out, b_cout, b_ovf}, {54'd0, 8'h00, 1'b1, 1'b0});
    for (int i = 0; i < 5; i++) begin
      b_lhs = 8'(i * 37 + 200);
      b_rhs = 8'(i * 11 + 3);
      b_cin = 1'(i % 2);
      bexp[i] = {1'b0, b_lhs} + {1'b0, b_rhs} + {8'd0, b_cin};
      @(negedge clk);
      check("b_full_rate_ready", {63'd0, b_in_ready}, 64'd1);
      @(posedge clk);
      #1;
      check("b_b2b", {54'd0, b_out_valid, b_cout, b_out}, {54'd0, 1'b1, bexp[i]});
    end
    b_in_valid = 0;
    @(posedge clk);
    #1;
    check("b_idle", {63'd0, b_out_valid}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
